// File: rtl/mcpu_pkg.sv
// Shared constants for the multicycle MIPS control path: state codes, opcode/funct
// values, ALU operation codes and datapath mux-select encodings.
package mcpu_pkg;

    localparam logic [3:0] S_IF    = 4'd0;
    localparam logic [3:0] S_ID    = 4'd1;
    localparam logic [3:0] S_MADDR = 4'd2;
    localparam logic [3:0] S_MRD   = 4'd3;
    localparam logic [3:0] S_MWB   = 4'd4;
    localparam logic [3:0] S_MWR   = 4'd5;
    localparam logic [3:0] S_REX   = 4'd6;
    localparam logic [3:0] S_RWB   = 4'd7;
    localparam logic [3:0] S_BR    = 4'd8;
    localparam logic [3:0] S_JMP   = 4'd9;
    localparam logic [3:0] S_IEX   = 4'd10;
    localparam logic [3:0] S_IWB   = 4'd11;
    localparam logic [3:0] S_JAL   = 4'd12;
    localparam logic [3:0] S_JR    = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REG    = 2'b11;

    // R-type arithmetic/logic functions executed through REX (jr is handled separately)
    function automatic logic rtype_alu_funct(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_NOR) || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// ALU operation decode: fixed ADD/SUB in fetch, decode, address and branch states,
// funct-driven in REX, opcode-driven in IEX.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_AND;
        case (state)
            S_IF, S_ID, S_MADDR: alu_op = ALU_ADD;
            S_BR:                alu_op = ALU_SUB;
            S_REX: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_AND;
                endcase
            end
            S_IEX: begin
                case (opcode)
                    OP_ADDI: alu_op = ALU_ADD;
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_SLTI: alu_op = ALU_SLT;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_AND;
                endcase
            end
            default: alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multicycle MIPS main control FSM: only the state register is clocked; register
// enables, mux selects and memory strobes are decoded from state (plus mem_ready/zero).
module mcpu_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_ce,
    output logic               ir_ce,
    output logic               mdr_ce,
    output logic               ab_ce,
    output logic               alu_out_ce,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [2:0]         alu_op,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    logic [3:0] state;
    logic [3:0] state_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IF;
        else     state <= state_nxt;
    end

    mcpu_alu_dec u_alu_dec (
        .state  (state),
        .opcode (opcode),
        .funct  (funct),
        .alu_op (alu_op)
    );

    always_comb begin
        state_nxt  = S_IF;
        pc_ce      = 1'b0;
        ir_ce      = 1'b0;
        mdr_ce     = 1'b0;
        ab_ce      = 1'b0;
        alu_out_ce = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = RDST_RT;
        mem_to_reg = WD_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        pc_src     = PCS_ALU;
        illegal    = 1'b0;
        case (state)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                if (mem_ready) begin
                    ir_ce     = 1'b1;
                    pc_ce     = 1'b1;
                    state_nxt = S_ID;
                end else begin
                    state_nxt = S_IF;
                end
            end
            // Decode also precomputes the branch target into ALUOut
            S_ID: begin
                ab_ce      = 1'b1;
                alu_out_ce = 1'b1;
                alu_src_b  = SRCB_IMM4;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MADDR;
                    OP_RTYPE: begin
                        if (funct == FN_JR)              state_nxt = S_JR;
                        else if (rtype_alu_funct(funct)) state_nxt = S_REX;
                        else                             illegal   = 1'b1;
                    end
                    OP_BEQ, OP_BNE:                              state_nxt = S_BR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI:   state_nxt = S_IEX;
                    OP_J:                                        state_nxt = S_JMP;
                    OP_JAL:                                      state_nxt = S_JAL;
                    default:                                     illegal   = 1'b1;
                endcase
            end
            S_MADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_out_ce = 1'b1;
                state_nxt  = (opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                mem_read  = 1'b1;
                i_or_d    = 1'b1;
                mdr_ce    = mem_ready;
                state_nxt = mem_ready ? S_MWB : S_MRD;
            end
            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = WD_MDR;
            end
            S_MWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_nxt = mem_ready ? S_IF : S_MWR;
            end
            S_REX: begin
                alu_src_a  = 1'b1;
                alu_out_ce = 1'b1;
                state_nxt  = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = RDST_RD;
            end
            S_IEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_out_ce = 1'b1;
                state_nxt  = S_IWB;
            end
            S_IWB: reg_write = 1'b1;
            S_BR: begin
                alu_src_a = 1'b1;
                pc_src    = PCS_ALUOUT;
                pc_ce     = (opcode == OP_BEQ) ? zero : ~zero;
            end
            S_JMP: begin
                pc_src = PCS_JUMP;
                pc_ce  = 1'b1;
            end
            // Register file takes PC+4 in the same cycle the PC moves to the target
            S_JAL: begin
                pc_src     = PCS_JUMP;
                pc_ce      = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = RDST_RA;
                mem_to_reg = WD_PC;
            end
            S_JR: begin
                alu_src_a = 1'b1;
                pc_src    = PCS_REG;
                pc_ce     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign dbg_state = STATE_W'(state);

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Randomized instruction-stream bench for mcpu_ctrl_fsm with a per-instruction
// reference model feeding a scoreboard that is drained once per cycle.
module tb_mcpu_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_ce, ir_ce, mdr_ce, ab_ce, alu_out_ce;
        logic       mem_read, mem_write, i_or_d, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, pc_src;
        logic [2:0] alu_op;
        logic       illegal;
    } obs_t;

    typedef enum int {K_BAD, K_LW, K_SW, K_R, K_JR, K_BR, K_I, K_J, K_JAL} kind_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_ce, ir_ce, mdr_ce, ab_ce, alu_out_ce, mem_read, mem_write, i_or_d, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic       alu_src_a, illegal;
    logic [2:0] alu_op;
    logic [3:0] dbg_state;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    obs_t  mon_e, mon_a;
    string mon_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcpu_ctrl_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_ce(pc_ce), .ir_ce(ir_ce), .mdr_ce(mdr_ce),
        .ab_ce(ab_ce), .alu_out_ce(alu_out_ce), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
        .illegal(illegal), .dbg_state(dbg_state)
    );

    // Monitor: one scoreboard entry per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            mon_a = {dbg_state, pc_ce, ir_ce, mdr_ce, ab_ce, alu_out_ce, mem_read, mem_write,
                     i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
                     alu_op, illegal};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL %s cyc %0d got %h expected %h", mon_t, cyc, mon_a, mon_e);
            end
        end
    end

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A}) return K_R;
                return K_BAD;
            end
            6'h04, 6'h05: return K_BR;
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return K_I;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_BAD;
        endcase
    endfunction

    // ALU codes: AND=0 OR=1 ADD=2 LUI=3 NOR=4 SUB=6 SLT=7
    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return 3'd2;
            6'h22: return 3'd6;
            6'h24: return 3'd0;
            6'h25: return 3'd1;
            6'h27: return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            6'h08: return 3'd2;
            6'h0C: return 3'd0;
            6'h0D: return 3'd1;
            6'h0A: return 3'd7;
            default: return 3'd3;
        endcase
    endfunction

    task automatic step(input logic rdy, input logic z, input obs_t e, input string tag);
        mem_ready = rdy;
        zero      = z;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // One full instruction: fetch (with wait cycles), decode, then the class's steps.
    // abort asserts reset during the memory-access wait of lw/sw.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int if_wait,
                             input int mem_wait, input logic z, input bit abort);
        obs_t  o;
        kind_t k;
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 3'd2;
        for (int i = 0; i < if_wait; i++) step(1'b0, rnd1(), o, "fetch_wait");
        o.pc_ce = 1'b1; o.ir_ce = 1'b1;
        step(1'b1, rnd1(), o, "fetch");
        opcode = op;
        funct  = fn;
        k = classify(op, fn);
        o = '0; o.st = 4'd1; o.ab_ce = 1'b1; o.alu_out_ce = 1'b1; o.alu_src_b = 2'b11;
        o.alu_op = 3'd2; o.illegal = (k == K_BAD);
        step(rnd1(), rnd1(), o, "decode");
        case (k)
            K_LW, K_SW: begin
                o = '0; o.st = 4'd2; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                o.alu_op = 3'd2; o.alu_out_ce = 1'b1;
                step(rnd1(), rnd1(), o, "mem_addr");
                o = '0; o.i_or_d = 1'b1;
                if (k == K_LW) begin o.st = 4'd3; o.mem_read = 1'b1; end
                else begin o.st = 4'd5; o.mem_write = 1'b1; end
                for (int i = 0; i < mem_wait; i++) step(1'b0, rnd1(), o, "mem_wait");
                if (abort) begin
                    rst = 1'b1;
                    step(1'b0, rnd1(), o, "mem_reset");
                    rst = 1'b0;
                end else begin
                    o.mdr_ce = (k == K_LW);
                    step(1'b1, rnd1(), o, "mem_ready");
                    if (k == K_LW) begin
                        o = '0; o.st = 4'd4; o.reg_write = 1'b1; o.mem_to_reg = 2'b01;
                        step(rnd1(), rnd1(), o, "lw_wb");
                    end
                end
            end
            K_R: begin
                o = '0; o.st = 4'd6; o.alu_src_a = 1'b1; o.alu_out_ce = 1'b1; o.alu_op = r_alu(fn);
                step(rnd1(), rnd1(), o, "r_exec");
                o = '0; o.st = 4'd7; o.reg_write = 1'b1; o.reg_dst = 2'b01;
                step(rnd1(), rnd1(), o, "r_wb");
            end
            K_JR: begin
                o = '0; o.st = 4'd13; o.alu_src_a = 1'b1; o.pc_src = 2'b11; o.pc_ce = 1'b1;
                step(rnd1(), rnd1(), o, "jr");
            end
            K_BR: begin
                o = '0; o.st = 4'd8; o.alu_src_a = 1'b1; o.alu_op = 3'd6; o.pc_src = 2'b01;
                o.pc_ce = (op == 6'h04) ? z : ~z;
                step(rnd1(), z, o, "branch");
            end
            K_I: begin
                o = '0; o.st = 4'd10; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                o.alu_out_ce = 1'b1; o.alu_op = i_alu(op);
                step(rnd1(), rnd1(), o, "i_exec");
                o = '0; o.st = 4'd11; o.reg_write = 1'b1;
                step(rnd1(), rnd1(), o, "i_wb");
            end
            K_J: begin
                o = '0; o.st = 4'd9; o.pc_src = 2'b10; o.pc_ce = 1'b1;
                step(rnd1(), rnd1(), o, "jump");
            end
            K_JAL: begin
                o = '0; o.st = 4'd12; o.pc_src = 2'b10; o.pc_ce = 1'b1; o.reg_write = 1'b1;
                o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
                step(rnd1(), rnd1(), o, "jal");
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] ops[13];
        logic [5:0] fns[8];
        logic [5:0] op, fn;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A,
                6'h0F, 6'h02, 6'h03};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h08, 6'h3F};
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(6'h23, 6'h00, 0, 0, 1'b0, 1'b0);   // lw, no waits
        run_instr(6'h08, 6'h00, 3, 0, 1'b0, 1'b0);   // fetch stalls 3 cycles
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, 1'b0);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'h05, 6'h00, 0, 0, 1'b1, 1'b0);
        run_instr(6'h05, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'h00, 6'h3F, 0, 0, 1'b0, 1'b0);
        run_instr(6'h2B, 6'h00, 0, 2, 1'b0, 1'b1);   // reset while waiting in MWR
        run_instr(6'h03, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr(6'h23, 6'h00, 1, 3, 1'b0, 1'b1);   // reset while waiting in MRD
        run_instr(6'h00, 6'h08, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 12)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), rnd1(),
                      ($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
